// File: rtl/psram_pkg.sv
// Shared constants, bus-state enumeration and command decode for the PSRAM model.
package psram_pkg;

  typedef enum logic [2:0] {
    ST_CMD, ST_ADDR, ST_WAIT, ST_RDATA, ST_WDATA, ST_IGNORE
  } state_e;

  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_FREAD  = 8'h0B;
  localparam logic [7:0] OP_QREAD  = 8'hEB;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_QWRITE = 8'h38;
  localparam logic [7:0] OP_QPI_EN = 8'h35;
  localparam logic [7:0] OP_QPI_EX = 8'hF5;
  localparam logic [7:0] OP_RDID   = 8'h9F;
  localparam logic [7:0] OP_RSTEN  = 8'h66;
  localparam logic [7:0] OP_RST    = 8'h99;

  localparam logic [3:0] WAIT_SPI_FAST = 4'd8;
  localparam logic [3:0] WAIT_QUAD     = 4'd6;
  localparam logic [3:0] WAIT_QPI_FAST = 4'd4;

  localparam logic [7:0] ID_MFR = 8'h0D;
  localparam logic [7:0] ID_KGD = 8'h5D;

  typedef struct packed {
    logic       ok;
    logic       quad;
    logic       wr;
    logic       id;
    logic [3:0] wait_clks;
  } cmd_t;

  // Only commands that proceed to an address phase are "ok"; mode commands are handled by the top.
  function automatic cmd_t decode(input logic [7:0] op, input logic qpi);
    cmd_t c;
    c = '0;
    if (!qpi) begin
      case (op)
        OP_READ:   c.ok = 1'b1;
        OP_FREAD:  begin c.ok = 1'b1; c.wait_clks = WAIT_SPI_FAST; end
        OP_QREAD:  begin c.ok = 1'b1; c.quad = 1'b1; c.wait_clks = WAIT_QUAD; end
        OP_WRITE:  begin c.ok = 1'b1; c.wr = 1'b1; end
        OP_QWRITE: begin c.ok = 1'b1; c.wr = 1'b1; c.quad = 1'b1; end
        OP_RDID:   begin c.ok = 1'b1; c.id = 1'b1; end
        default: ;
      endcase
    end else begin
      c.quad = 1'b1;
      case (op)
        OP_FREAD:            begin c.ok = 1'b1; c.wait_clks = WAIT_QPI_FAST; end
        OP_QREAD:            begin c.ok = 1'b1; c.wait_clks = WAIT_QUAD; end
        OP_WRITE, OP_QWRITE: begin c.ok = 1'b1; c.wr = 1'b1; end
        default: ;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/psram_shifter.sv
// Serial/quad receive shift register (rising edge) and transmit serializer (falling edge).
module psram_shifter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        quad_i,
  input  logic        drive_i,
  input  logic [3:0]  sio_i,
  input  logic [7:0]  tx_byte_i,
  input  logic [2:0]  tx_idx_i,
  output logic [23:0] rx_next_o,
  output logic [3:0]  dout_o,
  output logic [3:0]  oe_o
);

  logic [23:0] rx_q, rx_d;
  logic [3:0]  dout_q, oe_q;

  assign rx_d      = quad_i ? {rx_q[19:0], sio_i} : {rx_q[22:0], sio_i[0]};
  assign rx_next_o = rx_d;
  assign dout_o    = dout_q;
  assign oe_o      = oe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rx_q <= '0;
    else       rx_q <= rx_d;
  end

  // Single-bit reads only ever own SO (bit 1).
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dout_q <= '0;
      oe_q   <= '0;
    end else if (quad_i) begin
      dout_q <= tx_idx_i[0] ? tx_byte_i[3:0] : tx_byte_i[7:4];
      oe_q   <= {4{drive_i}};
    end else begin
      dout_q <= {2'b00, tx_byte_i[3'd7 - tx_idx_i], 1'b0};
      oe_q   <= {2'b00, drive_i, 1'b0};
    end
  end

endmodule

// File: rtl/esp_psram_64h.sv
// SPI/QPI PSRAM behavioural model: command/address/wait/data sequencing, byte array, mode and reset handling.
module esp_psram_64h
  import psram_pkg::*;
#(
  parameter int unsigned INDEX     = 0,
  parameter int unsigned MEM_BYTES = 8388608
) (
  input  logic       sclk,
  input  logic       csn,
  inout  wire  [3:0] sio
);

  localparam int          AW        = $clog2(MEM_BYTES);
  localparam logic [23:0] ADDR_MASK = 24'(MEM_BYTES - 1);

  state_e      state_q;
  logic [4:0]  cnt_q, len;
  logic [23:0] addr_q;
  logic        quad_q, wr_q, id_q;
  logic [3:0]  wait_q;
  logic        qpi_q   = 1'b0;
  logic        is66_q  = 1'b0;
  logic        armed_q = 1'b0;
  logic [7:0]  mem [MEM_BYTES];

  logic [23:0] rx_next;
  logic [3:0]  dout, oe;
  logic [7:0]  tx_byte;
  logic        last, sh_quad, mem_we;
  cmd_t        dec;

  assign dec     = decode(rx_next[7:0], qpi_q);
  assign sh_quad = (state_q == ST_CMD) ? qpi_q : quad_q;
  assign last    = (cnt_q == len - 5'd1);
  assign mem_we  = (state_q == ST_WDATA) && last;

  always_comb begin
    case (state_q)
      ST_CMD:  len = qpi_q  ? 5'd2 : 5'd8;
      ST_ADDR: len = quad_q ? 5'd6 : 5'd24;
      ST_WAIT: len = {1'b0, wait_q};
      default: len = quad_q ? 5'd2 : 5'd8;
    endcase
  end

  always_ff @(posedge sclk or posedge csn) begin
    if (csn) begin
      state_q <= ST_CMD;
      cnt_q   <= '0;
      addr_q  <= '0;
      quad_q  <= 1'b0;
      wr_q    <= 1'b0;
      id_q    <= 1'b0;
      wait_q  <= '0;
    end else begin
      cnt_q <= last ? 5'd0 : cnt_q + 5'd1;
      case (state_q)
        ST_CMD: if (last) begin
          quad_q  <= dec.quad;
          wr_q    <= dec.wr;
          id_q    <= dec.id;
          wait_q  <= dec.wait_clks;
          state_q <= dec.ok ? ST_ADDR : ST_IGNORE;
        end
        ST_ADDR: if (last) begin
          addr_q  <= id_q ? 24'd0 : (rx_next & ADDR_MASK);
          state_q <= wr_q ? ST_WDATA : ((wait_q == 4'd0) ? ST_RDATA : ST_WAIT);
        end
        ST_WAIT: if (last) state_q <= ST_RDATA;
        ST_RDATA, ST_WDATA: if (last) addr_q <= (addr_q + 24'd1) & ADDR_MASK;
        default: ;
      endcase
    end
  end

  // Mode flag and array survive csn; they only change on completed commands/bytes.
  always_ff @(posedge sclk) begin
    is66_q <= 1'b0;
    if (state_q == ST_CMD && last) begin
      if (rx_next[7:0] == OP_RSTEN)                    is66_q <= 1'b1;
      if (!qpi_q && rx_next[7:0] == OP_QPI_EN)         qpi_q  <= 1'b1;
      if (qpi_q && rx_next[7:0] == OP_QPI_EX)          qpi_q  <= 1'b0;
      if (armed_q && rx_next[7:0] == OP_RST)           qpi_q  <= 1'b0;
    end
    if (mem_we) mem[addr_q[AW-1:0]] <= rx_next[7:0];
  end

  // Reset-enable stays armed only across a transaction that was exactly 0x66.
  always_ff @(posedge csn) armed_q <= is66_q;

  always_comb begin
    tx_byte = mem[addr_q[AW-1:0]];
    if (id_q) begin
      case (addr_q)
        24'd0:   tx_byte = ID_MFR;
        24'd1:   tx_byte = ID_KGD;
        24'd2:   tx_byte = 8'(INDEX);
        default: tx_byte = 8'h00;
      endcase
    end
  end

  psram_shifter u_shifter (
    .clk_i     (sclk),
    .rst_i     (csn),
    .quad_i    (sh_quad),
    .drive_i   (state_q == ST_RDATA),
    .sio_i     (sio),
    .tx_byte_i (tx_byte),
    .tx_idx_i  (cnt_q[2:0]),
    .rx_next_o (rx_next),
    .dout_o    (dout),
    .oe_o      (oe)
  );

  for (genvar i = 0; i < 4; i++) begin : g_sio
    assign sio[i] = oe[i] ? dout[i] : 1'bz;
  end

endmodule

// File: tb/tb_esp_psram_64h.sv
// Scoreboard bench: stimulus queues expected read bytes, a monitor assembles and compares DUT output.
module tb_esp_psram_64h;

  localparam int MEMB = 65536;

  logic       sclk = 1'b0;
  logic       csn  = 1'b1;
  wire  [3:0] sio;
  logic [3:0] tb_do = 4'h0;
  logic [3:0] tb_oe = 4'h0;
  logic       mon_en = 1'b0;
  logic       mon_quad = 1'b0;
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  pullup (sio[0]);
  pullup (sio[1]);
  pullup (sio[2]);
  pullup (sio[3]);

  for (genvar i = 0; i < 4; i++) begin : g_drv
    assign sio[i] = tb_oe[i] ? tb_do[i] : 1'bz;
  end

  esp_psram_64h #(.INDEX(2), .MEM_BYTES(MEMB)) dut (
    .sclk (sclk),
    .csn  (csn),
    .sio  (sio)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: samples half a cycle after the DUT's falling-edge drive.
  initial begin : monitor
    logic [7:0] sh;
    int n;
    sh = 8'h00;
    n  = 0;
    forever begin
      @(posedge sclk);
      #1;
      if (!mon_en) n = 0;
      else begin
        if (mon_quad) begin sh = {sh[3:0], sio}; n += 4; end
        else          begin sh = {sh[6:0], sio[1]}; n += 1; end
        if (n == 8) begin
          n = 0;
          if (!mon_quad) check("idle_lines", 32'({sio[3:2], sio[0]}), 32'h7);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %h required none", sh);
          end else begin
            check("rd_byte", 32'(sh), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // All stimulus tasks start and end on a falling edge of sclk.
  task automatic clk1(input logic [3:0] d, input logic [3:0] oe);
    tb_do = d;
    tb_oe = oe;
    @(negedge sclk);
  endtask

  task automatic begin_tx();
    @(negedge sclk);
    csn = 1'b0;
  endtask

  task automatic end_tx();
    tb_oe  = 4'h0;
    mon_en = 1'b0;
    csn    = 1'b1;
    @(negedge sclk);
  endtask

  task automatic send(input logic [31:0] v, input int nbits, input logic quad);
    if (quad) for (int i = nbits - 4; i >= 0; i -= 4) clk1(v[i+:4], 4'hF);
    else      for (int i = nbits - 1; i >= 0; i--)    clk1({3'b000, v[i]}, 4'b0001);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk1(4'h0, 4'h0);
  endtask

  task automatic rd(input int nbytes, input logic quad);
    tb_oe    = 4'h0;
    mon_quad = quad;
    mon_en   = 1'b1;
    repeat (nbytes * (quad ? 2 : 8)) @(negedge sclk);
    end_tx();
  endtask

  task automatic spi_read(input logic [23:0] a, input int nbytes);
    begin_tx(); send(32'h03, 8, 1'b0); send(32'(a), 24, 1'b0); rd(nbytes, 1'b0);
  endtask

  task automatic cmd_only(input logic [7:0] op, input logic quad);
    begin_tx(); send(32'(op), 8, quad); end_tx();
  endtask

  initial begin
    repeat (2) @(negedge sclk);
    #1 check("reset_sio_z", 32'(sio), 32'hF);

    // SPI write 0xA5 0x3C at 0x10, then 1-bit read back
    begin_tx(); send(32'h02, 8, 0); send(32'h10, 24, 0); send(32'hA5, 8, 0); send(32'h3C, 8, 0); end_tx();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    spi_read(24'h000010, 2);

    // SPI fast read (8 waits) and SPI quad read (quad addr, 6 waits)
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    begin_tx(); send(32'h0B, 8, 0); send(32'h10, 24, 0); idle(8); rd(2, 0);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    begin_tx(); send(32'hEB, 8, 0); send(32'h10, 24, 1); idle(6); rd(2, 1);

    // Address bits above the array size alias
    exp_q.push_back(8'hA5);
    spi_read(24'h010010, 1);

    // Wrap from the last byte to byte 0
    begin_tx(); send(32'h02, 8, 0); send(MEMB - 1, 24, 0); send(32'h11, 8, 0); send(32'h22, 8, 0); end_tx();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    spi_read(24'(MEMB - 1), 2);
    exp_q.push_back(8'h22);
    spi_read(24'h000000, 1);

    // Read ID with INDEX=2
    exp_q.push_back(8'h0D); exp_q.push_back(8'h5D); exp_q.push_back(8'h02);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    begin_tx(); send(32'h9F, 8, 0); send(32'hABCDEF, 24, 0); rd(5, 0);

    // Abort mid-byte during a write: only the completed byte lands
    begin_tx(); send(32'h02, 8, 0); send(32'h20, 24, 0); send(32'h00, 8, 0); send(32'h00, 8, 0); end_tx();
    begin_tx(); send(32'h02, 8, 0); send(32'h20, 24, 0); send(32'h5A, 8, 0); send(32'hF, 4, 0); end_tx();
    exp_q.push_back(8'h5A); exp_q.push_back(8'h00);
    spi_read(24'h000020, 2);

    // Abort mid-read: sio released as soon as csn rises
    begin_tx(); send(32'h03, 8, 0); send(32'h21, 24, 0);
    tb_oe = 4'h0;
    repeat (3) @(negedge sclk);
    #1 check("read_drives_so", 32'(sio[1]), 32'h0);
    csn = 1'b1;
    #1 check("abort_sio_z", 32'(sio), 32'hF);
    @(negedge sclk);

    // Enter QPI, quad write, quad reads with 6 and 4 waits
    cmd_only(8'h35, 1'b0);
    begin_tx(); send(32'h38, 8, 1); send(32'h001000, 24, 1); send(32'h12345678, 32, 1); end_tx();
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    begin_tx(); send(32'hEB, 8, 1); send(32'h001000, 24, 1); idle(6); rd(4, 1);
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    begin_tx(); send(32'h0B, 8, 1); send(32'h001000, 24, 1); idle(4); rd(2, 1);

    // 0x03 is not a QPI command: bus stays released
    begin_tx(); send(32'h03, 8, 1); send(32'h001000, 24, 1);
    tb_oe = 4'h0;
    repeat (4) @(negedge sclk);
    #1 check("qpi_03_ignored", 32'(sio), 32'hF);
    end_tx();

    // Exit QPI, SPI read works again
    cmd_only(8'hF5, 1'b1);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    spi_read(24'h000010, 2);

    // Lone 0x99 keeps QPI; 0x66 then 0x99 returns to SPI
    cmd_only(8'h35, 1'b0);
    cmd_only(8'h99, 1'b1);
    exp_q.push_back(8'h12);
    begin_tx(); send(32'hEB, 8, 1); send(32'h001000, 24, 1); idle(6); rd(1, 1);
    cmd_only(8'h66, 1'b1);
    cmd_only(8'h99, 1'b1);
    exp_q.push_back(8'hA5);
    spi_read(24'h000010, 1);

    repeat (4) @(negedge sclk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/esp_psram_64h.md
ESP_PSRAM_64H -- requirements
Module: esp_psram_64h

Interface
REQ-001 SHALL have parameter INDEX, default 0: instance number (0..3), returned as the third Read-ID byte.
REQ-002 SHALL have parameter MEM_BYTES, default 8388608: array size in bytes (64 Mbit), power of two.
REQ-003 SHALL have port sclk, input, 1: the single clock; sio is sampled on rising and driven on falling edges.
REQ-004 SHALL have port csn, input, 1: chip deselect, used as the asynchronous active-high reset.
REQ-005 SHALL have port sio, inout, 4: data; bit 0 is SI/D0, bit 1 is SO/D1, bits 3:2 are D3:D2.

Function
REQ-006 SHALL provide a byte memory of MEM_BYTES; address = 24-bit address mod MEM_BYTES.
REQ-007 SHALL use bus states CMD, ADDR, WAIT, RDATA, WDATA, IGNORE.
- Each csn-low transaction starts in CMD.
REQ-008 SHALL use mode flag qpi: 0 = SPI (command on sio[0], 8 clocks), 1 = QPI (command on sio[3:0], 2 clocks).
- MSB/high nibble first.
REQ-009 SHALL take the address after the command: 24 bits, MSB first.
- 24 clocks on sio[0] for SPI commands.
- 6 clocks on sio[3:0] for quad commands or in QPI.
REQ-010 SHALL support these commands in SPI mode:
- 0x03 read: 1-bit, 0 wait.
- 0x0B fast read: 1-bit, 8 wait.
- 0xEB quad read: quad address/data, 6 wait.
- 0x02 write: 1-bit.
- 0x38 quad write.
- 0x35 enter QPI.
- 0x9F read ID.
- 0x66 reset-enable and 0x99 reset.
REQ-011 SHALL support these commands in QPI mode, all quad:
- 0x0B: 4 wait.
- 0xEB: 6 wait.
- 0x02 and 0x38: write.
- 0xF5: exit QPI.
- 0x66/0x99 reset.
REQ-012 SHALL apply 0x35 or 0xF5 at the rising edge of the last command clock; the new mode takes effect from the next transaction.
REQ-013 SHALL clear qpi on 0x99 only if the immediately preceding transaction was 0x66.
REQ-014 SHALL handle reads as follows:
- First data bit/nibble is driven on the falling edge after the last address/wait rising edge.
- Byte address increments after each byte and wraps from MEM_BYTES-1 to 0.
- Burst length is unlimited.
REQ-015 SHALL drive data only on the active outputs, and drive sio as Z at all other times:
- 1-bit reads drive sio[1] only.
- Quad reads drive sio[3:0].
REQ-016 SHALL handle writes as follows:
- Each complete received byte is written at the current address, then the address increments with the same wrap.
- A partial byte at csn rise is discarded.
REQ-017 SHALL handle 0x9F as follows:
- 24 don't-care address clocks, then output on sio[1].
- Output sequence is 0x0D, 0x5D, INDEX[7:0], then 0x00 repeating.
REQ-018 SHALL treat an unsupported command, or 0x9F/0x03/0x35 in QPI, as follows:
- Enter IGNORE.
- sio stays Z and memory is unchanged until csn rises.
REQ-019 SHALL abort any state at the rising edge of csn: no further writes, sio Z.

Reset
REQ-020 SHALL on csn=1, asynchronously:
- Return to CMD and clear the bit counter, address and shift registers.
- Release sio to Z.
- Clear the 0x66 armed flag unless the just-ended transaction was exactly 0x66.
REQ-021 SHALL leave qpi and memory contents unaffected by csn.
- qpi powers up 0.
- Memory powers up as don't-care (X in simulation).

Structure
REQ-022 SHALL place the command opcodes, wait counts (SPI fast 8, quad 6, QPI fast 4) and ID bytes 0x0D/0x5D as constants in a shared package psram_pkg.
REQ-023 SHALL place the state enumeration in psram_pkg.
REQ-024 SHALL factor the bit/nibble shift and serialize logic into one sub-module, psram_shifter (width 1 or 4 selectable).

Verification
REQ-025 SHALL check a SPI write then read:
- Stimulus: 0x02, address 0x000010, data 0xA5 0x3C; then 0x03 at 0x000010 for 2 bytes.
- Required response: sio[1] yields 0xA5 0x3C.
REQ-026 SHALL check a QPI round-trip:
- Stimulus: 0x35; then QPI 0x38 at 0x001000 with 0x12345678; then QPI 0xEB with 6 waits.
- Required response: nibbles 1,2,3,4,5,6,7,8.
REQ-027 SHALL check wrap:
- Stimulus: write 0x11 0x22 at address MEM_BYTES-1, then read at MEM_BYTES-1.
- Required response: 0x11 0x22; byte 0 now holds 0x22.
REQ-028 SHALL check Read ID with INDEX=2:
- Stimulus: 0x9F.
- Required response: 0x0D, 0x5D, 0x02, 0x00.
REQ-029 SHALL check abort:
- Stimulus: raise csn mid-byte during a 0x02 write.
- Required response: only completed bytes change; sio is Z immediately.
REQ-030 SHALL check QPI exit and reset:
- Stimulus: QPI 0xF5, then SPI 0x03; separately QPI 0x66 then 0x99.
- Required response: SPI mode restored in both cases.
- Required response: a lone 0x99 keeps QPI.
